fetch_unit: RTL and testbench

Instruction fetch stage that owns the architectural fetch PC, issues in-order requests to instruction memory, and buffers returned instructions for decode. It sits directly downstream of `branch_unit`: it consumes `flush` and `jump_addr` from that block to redirect fetch, and it discards every stale in-flight response and buffered instruction. Its output is a valid/ready stream of {pc, instr} pairs feeding the IF/ID boundary.

---
 rtl/fetch_if.sv | 33 +++
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bundle: redirect input, instruction-memory request/response and
// the {pc, instr} stream toward decode. master = fetch_unit side.
interface fetch_if;
    logic        flush;
    logic [31:0] jump_addr;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    modport master (
        input  flush, jump_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  if_ready,
        output imem_req_valid, imem_req_addr,
        output if_valid, if_instr, if_pc
    );

    modport slave (
        output flush, jump_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output if_ready,
        input  imem_req_valid, imem_req_addr,
        input  if_valid, if_instr, if_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order imem requests under a credit limit,
// buffers responses as {pc, instr}, and discards stale responses after a redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic    clk,
    input  logic    rst,
    fetch_if.master bus
);
    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic credit_ok;
    logic req_fire;
    logic pop;
    logic push;
    logic dropping;

    // Credit counts every outstanding request, including ones already marked
    // for dropping, so an accepted response can never find the buffer full.
    always_comb begin
        credit_ok          = ({1'b0, inflight} + {1'b0, count}) < DEPTH_C;
        bus.imem_req_valid = !rst && !bus.flush && credit_ok;
        bus.imem_req_addr  = rst ? RESET_PC : fetch_pc;
        req_fire           = bus.imem_req_valid && bus.imem_req_ready;

        bus.if_valid       = !rst && !bus.flush && (count != '0);
        bus.if_instr       = bus.if_valid ? instr_mem[rd_ptr] : NOP;
        bus.if_pc          = bus.if_valid ? pc_mem[rd_ptr]    : 32'h0;
        pop                = bus.if_valid && bus.if_ready;

        dropping           = (drop != '0);
        push               = bus.imem_rsp_valid && !bus.flush && !dropping;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (bus.flush) begin
            // No request issues in a flush cycle, so inflight only loses a
            // coincident response; everything still outstanding becomes stale.
            fetch_pc <= bus.jump_addr;
            rsp_pc   <= bus.jump_addr;
            inflight <= inflight - CW'(bus.imem_rsp_valid);
            drop     <= inflight - CW'(bus.imem_rsp_valid);
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            inflight <= inflight + CW'(req_fire) - CW'(bus.imem_rsp_valid);
            if (bus.imem_rsp_valid && dropping) begin
                drop <= drop - 1'b1;
            end
            if (push) begin
                rsp_pc <= rsp_pc + 32'd4;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem[wr_ptr]    <= rsp_pc;
            instr_mem[wr_ptr] <= bus.imem_rsp_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == CW'(DEPTH))));
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        !(bus.imem_rsp_valid && (inflight == '0)));
    a_inflight_bound: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, inflight} + {1'b0, count}) <= DEPTH_C);
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a queue-based memory and stream model
// (requests tagged by redirect epoch) predicts every output each cycle.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH    = 4;

    logic clk = 1'b0;
    logic rst;

    fetch_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    req_t        mem_q[$];
    ent_t        fifo_q[$];
    logic [31:0] exp_fetch;
    int          epoch    = 0;
    int          cyc      = 0;
    int          last_due = 0;
    int          lat      = 1;
    int          n_vec    = 0;
    int          n_err    = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Called just after a rising edge: drive one cycle, check, advance the model.
    task automatic cycle(input logic fl, input logic [31:0] ja, input logic rr,
                         input logic ir, input logic r);
        logic        rsp, fire, exp_rv, exp_iv;
        logic [31:0] fire_addr;
        req_t        hd, nr;
        ent_t        e;
        rsp = !r && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        rst                = r;
        bus.flush          = fl;
        bus.jump_addr      = fl ? ja : $urandom();
        bus.imem_req_ready = rr;
        bus.if_ready       = ir;
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : $urandom();
        #2;
        exp_rv = !r && !fl && ((mem_q.size() + fifo_q.size()) < DEPTH);
        exp_iv = !r && !fl && (fifo_q.size() != 0);
        check_eq("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        check_eq("req_addr", bus.imem_req_addr, r ? RESET_PC : exp_fetch);
        check_eq("if_valid", 32'(bus.if_valid), 32'(exp_iv));
        check_eq("if_pc", bus.if_pc, exp_iv ? fifo_q[0].pc : 32'h0);
        check_eq("if_instr", bus.if_instr, exp_iv ? fifo_q[0].instr : 32'h13);
        fire      = bus.imem_req_valid && rr;
        fire_addr = bus.imem_req_addr;
        @(posedge clk);
        #1;
        if (r) begin
            mem_q.delete();
            fifo_q.delete();
            exp_fetch = RESET_PC;
            epoch++;
        end else if (fl) begin
            if (rsp) void'(mem_q.pop_front());
            fifo_q.delete();
            exp_fetch = ja;
            epoch++;
        end else begin
            if (exp_iv && ir) void'(fifo_q.pop_front());
            if (rsp) begin
                hd = mem_q.pop_front();
                if (hd.epoch == epoch) begin
                    e.pc    = hd.addr;
                    e.instr = mem_word(hd.addr);
                    fifo_q.push_back(e);
                end
            end
            if (exp_rv && rr) exp_fetch += 32'd4;
            if (fire) begin
                last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                nr.addr  = fire_addr;
                nr.epoch = epoch;
                nr.due   = last_due;
                mem_q.push_back(nr);
            end
        end
        cyc++;
    endtask

    task automatic run(input int n, input int rr_pct, input int ir_pct);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 32'h0, ($urandom_range(0, 99) < rr_pct), ($urandom_range(0, 99) < ir_pct), 1'b0);
    endtask

    initial begin
        bit done;
        rst                = 1'b1;
        bus.flush          = 1'b0;
        bus.jump_addr      = 32'h0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.if_ready       = 1'b0;
        exp_fetch          = RESET_PC;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

        // free run through the 32-bit wrap, L=1
        lat = 1;
        run(40, 100, 100);

        // decode stall, L=2
        lat = 2;
        run(5, 100, 100);
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        run(20, 100, 100);

        // redirect with two responses outstanding, L=3
        lat = 3;
        done = 0;
        for (int i = 0; i < 40; i++) begin
            if (!done && mem_q.size() == 2) begin
                cycle(1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
                done = 1;
            end else begin
                cycle(1'b0, 32'h0, (i % 3) != 2, 1'b1, 1'b0);
            end
        end

        // redirect in the same cycle as a response, with decode ready
        lat = 2;
        done = 0;
        for (int i = 0; i < 30; i++) begin
            if (!done && mem_q.size() > 1 && mem_q[0].due <= cyc && fifo_q.size() > 0) begin
                cycle(1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
                done = 1;
            end else begin
                cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
            end
        end

        // back-to-back redirects
        run(5, 100, 100);
        cycle(1'b1, 32'h200, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h300, 1'b1, 1'b1, 1'b0);
        run(20, 100, 100);

        // randomized traffic with varying latency and redirects
        for (int blk = 0; blk < 20; blk++) begin
            lat = $urandom_range(1, 4);
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(0, 19) == 0)
                    cycle(1'b1, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC),
                          $urandom_range(0, 1), $urandom_range(0, 1), 1'b0);
                else
                    cycle(1'b0, 32'h0, ($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 70), 1'b0);
            end
        end

        // reset mid-stream with three requests outstanding
        lat = 4;
        done = 0;
        for (int i = 0; i < 40; i++) begin
            if (!done && mem_q.size() == 3) begin
                cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
                done = 1;
            end else begin
                cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
            end
        end
        lat = 1;
        run(20, 100, 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
